reg_bank: RTL

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_if.sv | 29 ++
 rtl/reg_bank.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reg_bank_if.sv
// reg_bank_if: bus bundle for the reg_bank register file.
// One write port, two independent registered read ports, plus the
// ready / wr_drop status outputs of the bank.
interface reg_bank_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             re_a;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic             re_b;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic             ready;
  logic             wr_drop;

  modport master (
    output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rdata_b, ready, wr_drop
  );

  modport slave (
    input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rdata_b, ready, wr_drop
  );
endinterface

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file with one write port and two
// registered read ports (1-cycle latency).
// After reset a CLEAR sweep zeroes every entry, one per cycle; only then
// does the bank report ready and accept accesses. The storage itself is
// never reset, so the sweep is the only thing that defines its contents.
// Out-of-range or not-ready writes are dropped and flagged on wr_drop.
// Optional feature: define REG_BANK_BYPASS_EN to forward same-edge write
// data to a read of the same address; otherwise that read returns the
// pre-write entry value.
module reg_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic      clkout,
  input  logic      rst,
  reg_bank_if.slave bus
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [AW-1:0]    cnt_r;
  logic [AW-1:0]    cnt_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_a_r;
  logic [WIDTH-1:0] rdata_b_r;
  logic             wr_drop_r;

  logic             waddr_ok_s;
  logic             raddr_a_ok_s;
  logic             raddr_b_ok_s;
  logic             wr_ok_s;
  logic             wr_bad_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;

  // A power-of-two depth has no unused address codes, so the range
  // check collapses to constant true there.
  if (DEPTH == (1 << AW)) begin : g_full_range
    assign waddr_ok_s   = 1'b1;
    assign raddr_a_ok_s = 1'b1;
    assign raddr_b_ok_s = 1'b1;
  end else begin : g_part_range
    assign waddr_ok_s   = (bus.waddr   <= LAST);
    assign raddr_a_ok_s = (bus.raddr_a <= LAST);
    assign raddr_b_ok_s = (bus.raddr_b <= LAST);
  end

  // A write commits only in RUN with a valid address; any other write is dropped.
  always_comb begin
    wr_ok_s  = 1'b0;
    wr_bad_s = 1'b0;
    if (bus.we) begin
      wr_ok_s  = (state_r == RUN) && waddr_ok_s;
      wr_bad_s = !((state_r == RUN) && waddr_ok_s);
    end else begin
      wr_ok_s  = 1'b0;
      wr_bad_s = 1'b0;
    end
  end

  // Next state and sweep counter: walk every entry once, then settle in RUN.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == LAST) begin
          state_s = RUN;
          cnt_s   = '0;
        end else begin
          state_s = CLEAR;
          cnt_s   = cnt_r + AW'(1);
        end
      end
      RUN: begin
        state_s = RUN;
        cnt_s   = '0;
      end
      default: begin
        state_s = CLEAR;
        cnt_s   = '0;
      end
    endcase
  end

  // State and sweep counter registers; reset restarts the sweep from entry 0.
  always_ff @(posedge clkout) begin
    if (rst) begin
      state_r <= CLEAR;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Read-port A data select: out-of-range reads yield 0, optional forwarding.
  always_comb begin
    rd_a_s = '0;
    if (!raddr_a_ok_s) begin
      rd_a_s = '0;
    end else if (BYPASS && wr_ok_s && (bus.waddr == bus.raddr_a)) begin
      rd_a_s = bus.wdata;
    end else begin
      rd_a_s = mem_r[bus.raddr_a];
    end
  end

  // Read-port B data select: same rules as port A, fully independent.
  always_comb begin
    rd_b_s = '0;
    if (!raddr_b_ok_s) begin
      rd_b_s = '0;
    end else if (BYPASS && wr_ok_s && (bus.waddr == bus.raddr_b)) begin
      rd_b_s = bus.wdata;
    end else begin
      rd_b_s = mem_r[bus.raddr_b];
    end
  end

  // Storage: zeroed by the CLEAR sweep, written by accepted RUN writes; never reset directly.
  always_ff @(posedge clkout) begin
    if (!rst) begin
      if (state_r == CLEAR) begin
        mem_r[cnt_r] <= '0;
      end else if (wr_ok_s) begin
        mem_r[bus.waddr] <= bus.wdata;
      end
    end
  end

  // Registered outputs: read data loads only on an enabled read in RUN, drop pulse per rejected write.
  always_ff @(posedge clkout) begin
    if (rst) begin
      rdata_a_r <= '0;
      rdata_b_r <= '0;
      wr_drop_r <= 1'b0;
    end else begin
      wr_drop_r <= wr_bad_s;
      if ((state_r == RUN) && bus.re_a) begin
        rdata_a_r <= rd_a_s;
      end
      if ((state_r == RUN) && bus.re_b) begin
        rdata_b_r <= rd_b_s;
      end
    end
  end

  assign bus.rdata_a = rdata_a_r;
  assign bus.rdata_b = rdata_b_r;
  assign bus.wr_drop = wr_drop_r;
  assign bus.ready   = (state_r == RUN);

endmodule
